// File: rtl/convert8to32.sv
// convert8to32: byte-to-word packer.
// Collects four consecutive bytes (little-endian, first byte in [7:0]) into a
// 32-bit word presented with a valid/ready handshake. A sticky overrun flag
// records any completed word dropped because the output was still occupied.
module convert8to32 (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        sync,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [1:0]  lane,
  output logic        overrun
);

  logic [23:0] shadow;

  logic [1:0]  lane_nxt;
  logic [23:0] shadow_nxt;
  logic [31:0] word_out_nxt;
  logic        word_valid_nxt;
  logic        overrun_nxt;

  logic        accept;
  logic        complete;
  logic        out_free;
  logic        pop;
  logic [31:0] candidate;

  // Handshake decode: a word completes on a lane-3 accept; the output
  // register is free when empty or being popped in the same cycle.
  always_comb begin
    accept    = byte_valid && !sync;
    complete  = accept && (lane == 2'd3);
    out_free  = !word_valid || word_ready;
    pop       = word_valid && word_ready;
    candidate = {byte_in, shadow};
  end

  // Next-state computation for lane, shadow, output word and flags.
  always_comb begin
    lane_nxt       = lane;
    shadow_nxt     = shadow;
    word_out_nxt   = word_out;
    word_valid_nxt = word_valid;
    overrun_nxt    = overrun;

    // Consume; a completion below may immediately refill the register.
    if (pop) begin
      word_valid_nxt = 1'b0;
    end

    if (sync) begin
      // Realign: the partial word is abandoned; a coincident byte opens lane 0.
      if (byte_valid) begin
        shadow_nxt[7:0] = byte_in;
        lane_nxt        = 2'd1;
      end else begin
        lane_nxt        = 2'd0;
      end
    end else if (accept) begin
      unique case (lane)
        2'd0: shadow_nxt[7:0]   = byte_in;
        2'd1: shadow_nxt[15:8]  = byte_in;
        2'd2: shadow_nxt[23:16] = byte_in;
        default: begin
          if (out_free) begin
            word_out_nxt   = candidate;
            word_valid_nxt = 1'b1;
          end else begin
            overrun_nxt    = 1'b1;
          end
        end
      endcase
      lane_nxt = lane + 2'd1;
    end

    if (complete && !out_free) begin
      // Dropped word leaves the occupied output untouched.
      word_out_nxt   = word_out;
      word_valid_nxt = word_valid;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane       <= '0;
      shadow     <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      lane       <= lane_nxt;
      shadow     <= shadow_nxt;
      word_out   <= word_out_nxt;
      word_valid <= word_valid_nxt;
      overrun    <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_convert8to32.sv
// Self-checking bench for convert8to32: table-driven vectors plus a gapped
// stream sequence. Inputs change on the falling edge; outputs are sampled
// 1 time unit after the rising edge.
module tb_convert8to32;

  logic        clk;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        sync;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [1:0]  lane;
  logic        overrun;

  int unsigned n_checks;
  int unsigned n_fail;

  convert8to32 dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .sync       (sync),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .lane       (lane),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        bv;
    logic        sy;
    logic        rdy;
    logic [7:0]  b;
    logic [31:0] wo;
    logic        wv;
    logic [1:0]  ln;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic bv, logic sy, logic rdy,
                              logic [7:0] b, logic [31:0] wo, logic wv,
                              logic [1:0] ln, logic ov);
    vec_t v;
    v.rst = rst; v.bv = bv; v.sy = sy; v.rdy = rdy; v.b = b;
    v.wo = wo; v.wv = wv; v.ln = ln; v.ov = ov;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample after it.
  task automatic step(input logic rst, input logic bv, input logic sy,
                      input logic rdy, input logic [7:0] b);
    @(negedge clk);
    reset      = rst;
    byte_valid = bv;
    sync       = sy;
    word_ready = rdy;
    byte_in    = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    byte_valid = 1'b0;
    sync       = 1'b0;
    word_ready = 1'b0;
    byte_in    = '0;

    //              rst bv sy rdy byte   word_out      wv ln ov
    // Reset
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'h00000000, 0, 0, 0));
    // Basic pack, consumer stalled
    vecs.push_back(mk(0, 1, 0, 0, 8'h11, 32'h00000000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h22, 32'h00000000, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h33, 32'h00000000, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h44, 32'h44332211, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 32'h44332211, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 32'h44332211, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 32'h44332211, 0, 0, 0));
    // Streaming with word_ready held high
    vecs.push_back(mk(0, 1, 0, 1, 8'h01, 32'h44332211, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h02, 32'h44332211, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h03, 32'h44332211, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h04, 32'h04030201, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h05, 32'h04030201, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h06, 32'h04030201, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h07, 32'h04030201, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h08, 32'h08070605, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 32'h08070605, 0, 0, 0));
    // Overrun: eight bytes, consumer stalled
    vecs.push_back(mk(0, 1, 0, 0, 8'hA0, 32'h08070605, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA1, 32'h08070605, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA2, 32'h08070605, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA3, 32'hA3A2A1A0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA4, 32'hA3A2A1A0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA5, 32'hA3A2A1A0, 1, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA6, 32'hA3A2A1A0, 1, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA7, 32'hA3A2A1A0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 32'hA3A2A1A0, 1, 0, 1));
    // Reset clears sticky overrun
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'h00000000, 0, 0, 0));
    // Simultaneous pop and push
    vecs.push_back(mk(0, 1, 0, 0, 8'hA0, 32'h00000000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA1, 32'h00000000, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA2, 32'h00000000, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA3, 32'hA3A2A1A0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hB0, 32'hA3A2A1A0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hB1, 32'hA3A2A1A0, 1, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hB2, 32'hA3A2A1A0, 1, 3, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'hB3, 32'hB3B2B1B0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 32'hB3B2B1B0, 0, 0, 0));
    // Sync with a coincident byte realigns to lane 0
    vecs.push_back(mk(0, 1, 0, 0, 8'h55, 32'hB3B2B1B0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h66, 32'hB3B2B1B0, 0, 2, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h77, 32'hB3B2B1B0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h88, 32'hB3B2B1B0, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h99, 32'hB3B2B1B0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hAA, 32'hAA998877, 1, 0, 0));
    // Sync at lane 3 while output is full: no completion, no overrun
    vecs.push_back(mk(0, 1, 0, 0, 8'h01, 32'hAA998877, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h02, 32'hAA998877, 1, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h03, 32'hAA998877, 1, 3, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h04, 32'hAA998877, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 32'hAA998877, 0, 0, 0));
    // Reset mid-word overrides a coincident byte
    vecs.push_back(mk(0, 1, 0, 0, 8'h13, 32'hAA998877, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h14, 32'hAA998877, 0, 2, 0));
    vecs.push_back(mk(1, 1, 0, 1, 8'h15, 32'h00000000, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].bv, vecs[i].sy, vecs[i].rdy, vecs[i].b);
      check("word_out",   i, word_out,            vecs[i].wo);
      check("word_valid", i, {31'd0, word_valid}, {31'd0, vecs[i].wv});
      check("lane",       i, {30'd0, lane},       {30'd0, vecs[i].ln});
      check("overrun",    i, {31'd0, overrun},    {31'd0, vecs[i].ov});
    end

    // Gapped stream: lane advances only on valid bytes.
    begin
      logic [7:0] gb [4];
      gb[0] = 8'h11; gb[1] = 8'h22; gb[2] = 8'h33; gb[3] = 8'h44;
      for (int k = 0; k < 4; k++) begin
        logic [1:0] exp_ln;
        exp_ln = 2'(k + 1);
        step(0, 1, 0, 0, gb[k]);
        check("gap_lane", 100 + k, {30'd0, lane}, {30'd0, exp_ln});
        for (int g = 0; g < 2; g++) begin
          step(0, 0, 0, 0, 8'hFF);
          check("gap_hold_lane",  200 + k * 2 + g, {30'd0, lane}, {30'd0, exp_ln});
          check("gap_hold_valid", 200 + k * 2 + g, {31'd0, word_valid},
                (k == 3) ? 32'd1 : 32'd0);
        end
      end
      check("gap_word",  300, word_out, 32'h44332211);
      step(0, 0, 0, 1, 8'h00);
      check("gap_pop_valid", 301, {31'd0, word_valid}, 32'd0);
      check("gap_overrun",   301, {31'd0, overrun},    32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
